// File: rtl/pixel_window_buffer_if.sv
`timescale 1ns/1ps
// pixel_window_buffer_if
// Groups the frame-control, fetch and window handshake signals of
// pixel_window_buffer into one bundle.
//   slave  : the window buffer's view. It receives start/dims/fetched data/ready
//            and drives re, window, window_valid, busy, done and cfg_err.
//   master : the environment's view, which is the slave view with directions flipped.
// Signals:
//   start          1-cycle pulse that begins a frame and latches img_width/img_height
//   img_width      pixels per row (4..MAX_WIDTH, multiple of 4)
//   img_height     rows (>= 3)
//   greyscale_data four packed 8-bit pixels; pixel k at [8k+7:8k], k=0 leftmost
//   read_complete  greyscale_data is valid this cycle
//   re             read request towards the bus master
//   window         3x3 window; pixel(r,c) at [8*(3r+c)+:8]
//   window_valid   window carries a valid window
//   window_ready   consumer takes the window when valid && ready
//   busy           a frame is in progress
//   done           1-cycle pulse once the final window has been accepted
//   cfg_err        sticky flag: start was seen with illegal dimensions
interface pixel_window_buffer_if;
  logic        start;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic [31:0] greyscale_data;
  logic        read_complete;
  logic        re;
  logic [71:0] window;
  logic        window_valid;
  logic        window_ready;
  logic        busy;
  logic        done;
  logic        cfg_err;

  modport slave (
    input  start, img_width, img_height, greyscale_data, read_complete, window_ready,
    output re, window, window_valid, busy, done, cfg_err
  );

  modport master (
    output start, img_width, img_height, greyscale_data, read_complete, window_ready,
    input  re, window, window_valid, busy, done, cfg_err
  );
endinterface

// File: rtl/pixel_window_buffer.sv
`timescale 1ns/1ps
// pixel_window_buffer
// Unpacks fetched 32-bit greyscale words into pixels, keeps the two previous
// image rows in line buffers and emits one 3x3 window per interior pixel in
// raster order. Fetching is throttled through re, so a word is only requested
// once the previous one has been fully unpacked.
// Ports:
//   clk    rising-edge clock
//   n_rst  synchronous reset, active high (1 = reset)
//   bus    pixel_window_buffer_if.slave (frame control, fetch path, window output)
module pixel_window_buffer #(
  parameter int MAX_WIDTH = 640,
  parameter int PIX_W     = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  pixel_window_buffer_if.slave  bus
);

  localparam int          AW       = $clog2(MAX_WIDTH);
  localparam logic [15:0] MAX_W16  = 16'(MAX_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_UNPACK = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [15:0]        r_width;
  logic [31:0]        r_total_words;
  logic [31:0]        r_words;
  logic [31:0]        r_word;
  logic [2:0]         r_nib;
  logic [15:0]        r_col;
  logic [15:0]        r_row;
  logic [PIX_W-1:0]   r_win [9];
  logic               r_valid;
  logic               r_re;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;

  // Line-buffer contents are never reset; every location is written before
  // it contributes to a valid window.
  logic [PIX_W-1:0]   r_lb0 [MAX_WIDTH];
  logic [PIX_W-1:0]   r_lb1 [MAX_WIDTH];

  logic               w_dims_ok;
  logic               w_adv;
  logic               w_accept;
  logic [PIX_W-1:0]   w_pix;
  logic [AW-1:0]      w_addr;
  logic [PIX_W-1:0]   w_lb0_rd;
  logic [PIX_W-1:0]   w_lb1_rd;
  logic               w_new_win;
  logic [31:0]        w_prod;
  logic [9*PIX_W-1:0] w_window;

  assign w_dims_ok = (bus.img_width >= 16'd4) && (bus.img_width <= MAX_W16) &&
                     (bus.img_width[1:0] == 2'b00) && (bus.img_height >= 16'd3);
  assign w_prod    = {16'd0, bus.img_width} * {16'd0, bus.img_height};

  // Unpacking advances only when the window register is free or being taken.
  assign w_adv     = !r_valid || bus.window_ready;
  assign w_accept  = (r_state == S_UNPACK) && w_adv;
  // The word register shifts right after each pixel, so the next pixel is always the low byte.
  assign w_pix     = r_word[PIX_W-1:0];
  assign w_addr    = r_col[AW-1:0];
  assign w_lb0_rd  = r_lb0[w_addr];
  assign w_lb1_rd  = r_lb1[w_addr];
  assign w_new_win = (r_row >= 16'd2) && (r_col >= 16'd2);

  // Next-state logic of the frame FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start && w_dims_ok) w_next_state = S_REQ;
        else                        w_next_state = S_IDLE;
      end
      S_REQ: begin
        if (bus.read_complete) w_next_state = S_UNPACK;
        else                   w_next_state = S_REQ;
      end
      S_UNPACK: begin
        if (w_accept && (r_nib == 3'd1)) begin
          if (r_words < r_total_words) w_next_state = S_REQ;
          else                         w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_UNPACK;
        end
      end
      S_DRAIN: begin
        // Leave once the last window is gone or is being handed over this cycle.
        if (!r_valid || bus.window_ready) w_next_state = S_DONE;
        else                              w_next_state = S_DRAIN;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control state, counters, window registers and registered outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state       <= S_IDLE;
      r_width       <= 16'd0;
      r_total_words <= 32'd0;
      r_words       <= 32'd0;
      r_word        <= 32'd0;
      r_nib         <= 3'd0;
      r_col         <= 16'd0;
      r_row         <= 16'd0;
      r_valid       <= 1'b0;
      r_re          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      for (int i = 0; i < 9; i++) r_win[i] <= {PIX_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_re    <= (w_next_state == S_REQ);
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);

      if ((r_state == S_IDLE) && bus.start) begin
        r_cfg_err <= !w_dims_ok;
        if (w_dims_ok) begin
          r_width       <= bus.img_width;
          r_total_words <= w_prod >> 2;
          r_words       <= 32'd0;
          r_col         <= 16'd0;
          r_row         <= 16'd0;
        end
      end

      if ((r_state == S_REQ) && bus.read_complete) begin
        r_word  <= bus.greyscale_data;
        r_nib   <= 3'd4;
        r_words <= r_words + 32'd1;
      end else if (w_accept) begin
        r_word <= {8'd0, r_word[31:8]};
        r_nib  <= r_nib - 3'd1;
      end

      if (w_accept) begin
        if (r_col == (r_width - 16'd1)) begin
          r_col <= 16'd0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
        // Shift the window one column left; the new right column is
        // two rows back (top), one row back (middle) and the incoming pixel.
        for (int r = 0; r < 3; r++) begin
          r_win[3*r]     <= r_win[3*r + 1];
          r_win[3*r + 1] <= r_win[3*r + 2];
        end
        r_win[2] <= w_lb1_rd;
        r_win[5] <= w_lb0_rd;
        r_win[8] <= w_pix;
      end

      if (w_accept)               r_valid <= w_new_win;
      else if (bus.window_ready)  r_valid <= 1'b0;
    end
  end

  // Line buffers: read-before-write at the current column, one write each per pixel.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_addr] <= w_lb0_rd;
      r_lb0[w_addr] <= w_pix;
    end
  end

  // Pack the window registers into the output bus.
  always_comb begin
    w_window = {(9*PIX_W){1'b0}};
    for (int i = 0; i < 9; i++) w_window[PIX_W*i +: PIX_W] = r_win[i];
  end

  assign bus.window       = w_window;
  assign bus.window_valid = r_valid;
  assign bus.re           = r_re;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_pixel_window_buffer.sv
`timescale 1ns/1ps
// Directed testbench for pixel_window_buffer. Expected windows are computed
// from an image model and queued when a frame is started; a monitor pops and
// compares them on every window handshake.
module tb_pixel_window_buffer;

  logic clk = 1'b0;
  logic n_rst;
  pixel_window_buffer_if bus ();

  pixel_window_buffer dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int win_seen = 0;
  int done_seen = 0;
  int re_rises = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  bit re_prev = 1'b0;
  int cur_w = 4;
  int img_mode = 0;
  logic [71:0] exp_q [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Image model: mode 0 numbers pixels in raster order, mode 1 uses 16*row+col.
  function automatic logic [7:0] pix(input int r, input int c);
    if (img_mode == 1) return 8'(16 * r + c);
    else               return 8'(r * cur_w + c);
  endfunction

  function automatic logic [31:0] word_at(input int idx);
    logic [31:0] wd;
    int pos;
    wd = 32'd0;
    for (int k = 0; k < 4; k++) begin
      pos = 4 * idx + k;
      wd[8*k +: 8] = pix(pos / cur_w, pos % cur_w);
    end
    return wd;
  endfunction

  // Window produced when the pixel at (r,c) is accepted; centre is (r-1,c-1).
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v;
    v = 72'd0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        v[8*(3*rr + cc) +: 8] = pix(r - 2 + rr, c - 2 + cc);
    return v;
  endfunction

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.window_valid && bus.window_ready) begin
      chk("exp_avail", {71'd0, exp_q.size() != 0}, 72'd1);
      if (exp_q.size() != 0) chk("window", bus.window, exp_q.pop_front());
      win_seen++;
      last_hs_cyc = cyc;
    end
    if (bus.done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (bus.re && !re_prev) re_rises++;
    re_prev = bus.re;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_window"}, bus.window, 72'd0);
    chk({tag, "_valid"},  {71'd0, bus.window_valid}, 72'd0);
    chk({tag, "_re"},     {71'd0, bus.re}, 72'd0);
    chk({tag, "_busy"},   {71'd0, bus.busy}, 72'd0);
    chk({tag, "_done"},   {71'd0, bus.done}, 72'd0);
    chk({tag, "_cfg_err"},{71'd0, bus.cfg_err}, 72'd0);
  endtask

  task automatic run_frame(input int w, input int h, input int mode, input bit stall,
                           input bit restart, input int abort_words);
    int widx, win0, done0, rr0, stall_left, exp_n;
    bit fin, stall_started, rs_state, abort_arm;
    logic [71:0] snap;
    cur_w = w;
    img_mode = mode;
    exp_n = 0;
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        exp_q.push_back(exp_win(r, c));
        exp_n++;
      end
    win0 = win_seen; done0 = done_seen; rr0 = re_rises;
    bus.img_width = 16'(w);
    bus.img_height = 16'(h);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    widx = 0; fin = 1'b0; stall_left = 0; stall_started = 1'b0;
    rs_state = 1'b0; abort_arm = 1'b0; snap = 72'd0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      if (abort_arm) begin
        n_rst = 1'b1;
        bus.read_complete = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        chk_all_zero("abort");
        exp_q.delete();
        return;
      end
      // Bus-master model: answer each request with the next word.
      if (bus.re && !bus.read_complete) begin
        bus.greyscale_data = word_at(widx);
        bus.read_complete = 1'b1;
        widx++;
        if (abort_words != 0 && widx == abort_words) abort_arm = 1'b1;
      end else begin
        bus.read_complete = 1'b0;
      end
      // A second start mid-frame with other dimensions must be ignored.
      if (restart && widx == 1 && !rs_state) begin
        bus.start = 1'b1;
        bus.img_width = 16'd8;
        rs_state = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (stall) begin
        if (stall_left > 0) begin
          chk("stall_window", bus.window, snap);
          chk("stall_valid", {71'd0, bus.window_valid}, 72'd1);
          chk("stall_re", {71'd0, bus.re}, 72'd0);
          stall_left--;
          if (stall_left == 0) bus.window_ready = 1'b1;
        end else if (!stall_started && bus.window_valid) begin
          stall_started = 1'b1;
          snap = bus.window;
          bus.window_ready = 1'b0;
          stall_left = 5;
        end
      end
      if (bus.done) fin = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("done_in_time", {71'd0, fin}, 72'd1);
    bus.read_complete = 1'b0;
    bus.window_ready = 1'b1;
    @(posedge clk); #1;
    chk("window_count", 72'(win_seen - win0), 72'(exp_n));
    chk("done_count", 72'(done_seen - done0), 72'd1);
    chk("queue_empty", 72'(exp_q.size()), 72'd0);
    chk("done_latency", 72'(done_cyc - last_hs_cyc), 72'd1);
    chk("done_pulse", {71'd0, bus.done}, 72'd0);
    chk("busy_after", {71'd0, bus.busy}, 72'd0);
    chk("words_fetched", 72'(widx), 72'(w * h / 4));
    chk("re_pulses", 72'(re_rises - rr0), 72'(w * h / 4));
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    n_rst = 1'b1;
    bus.start = 1'b0;
    bus.img_width = 16'd0;
    bus.img_height = 16'd0;
    bus.greyscale_data = 32'd0;
    bus.read_complete = 1'b0;
    bus.window_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    chk_all_zero("reset");

    // T1: basic 4x3 frame
    run_frame(4, 3, 0, 1'b0, 1'b0, 0);
    // T2: consumer back-pressure after the first window
    run_frame(4, 3, 0, 1'b1, 1'b0, 0);
    // T3: 8x4 frame, pixel = 16*r+c
    run_frame(8, 4, 1, 1'b0, 1'b0, 0);

    // T4: illegal dimensions
    bus.img_width = 16'd6; bus.img_height = 16'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("w6_cfg_err", {71'd0, bus.cfg_err}, 72'd1);
    chk("w6_busy", {71'd0, bus.busy}, 72'd0);
    chk("w6_re", {71'd0, bus.re}, 72'd0);
    bus.img_width = 16'd4; bus.img_height = 16'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("h2_cfg_err", {71'd0, bus.cfg_err}, 72'd1);
    chk("h2_busy", {71'd0, bus.busy}, 72'd0);
    chk("h2_re", {71'd0, bus.re}, 72'd0);
    run_frame(4, 3, 0, 1'b0, 1'b0, 0);
    chk("legal_clears_cfg_err", {71'd0, bus.cfg_err}, 72'd0);

    // T5: reset while unpacking row 1, then a clean frame
    d0 = done_seen;
    run_frame(4, 3, 0, 1'b0, 1'b0, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 72'(done_seen - d0), 72'd0);
    chk("abort_idle_busy", {71'd0, bus.busy}, 72'd0);
    run_frame(4, 3, 0, 1'b0, 1'b0, 0);

    // T6: start during busy is ignored
    run_frame(4, 3, 0, 1'b0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
